mc_control: RTL and testbench

Multi-cycle sequencer for the MIPS-subset datapath. It replaces single-cycle control, stepping each instruction through fetch, decode, execute, memory and writeback states. This lets one shared ALU and one shared instruction/data memory port serve the whole instruction. It sits beside the datapath, takes opcode/function from the instruction register plus ALU flags and a memory ready strobe, and drives every datapath enable and mux select.

---
 rtl/mc_control_if.sv | 40 ++++
 rtl/mc_control.sv | 174 +++++++++++++++++
 tb/tb_mc_control.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Datapath-facing bundle of the multi-cycle sequencer:
// IR fields and ALU/memory status in, datapath controls out.
interface mc_control_if;
  logic [5:0]  Op;
  logic [5:0]  Fun;
  logic        equal;
  logic        sign;
  logic        mem_ready;
  logic        PCWr;
  logic        nPC_sel;
  logic        IRWr;
  logic        IorD;
  logic        MemRd;
  logic        MemWr;
  logic        RegWr;
  logic        RegDst;
  logic        MemToReg;
  logic        ExtOp;
  logic        ALUSrc;
  logic [2:0]  ALUctr;
  logic        halt;
  logic [3:0]  state;
  logic [31:0] retired;

  modport master (
    input  Op, Fun, equal, sign, mem_ready,
    output PCWr, nPC_sel, IRWr, IorD,
    output MemRd, MemWr, RegWr, RegDst,
    output MemToReg, ExtOp, ALUSrc, ALUctr,
    output halt, state, retired
  );

  modport slave (
    output Op, Fun, equal, sign, mem_ready,
    input  PCWr, nPC_sel, IRWr, IorD,
    input  MemRd, MemWr, RegWr, RegDst,
    input  MemToReg, ExtOp, ALUSrc, ALUctr,
    input  halt, state, retired
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle control sequencer for the MIPS-subset datapath:
// fetch/decode/exec/mem/writeback stepping with retire counter.
module mc_control (
  input logic          clk,
  input logic          reset,
  mc_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    WB     = 4'd3,
    ADDR   = 4'd4,
    MEM    = 4'd5,
    LWB    = 4'd6,
    BRANCH = 4'd7,
    TRAP   = 4'd8
  } state_t;

  state_t      st;
  state_t      nxt;
  logic        retire;
  logic [31:0] retired_q;

  logic is_r, is_addi, is_lw, is_sw;
  logic is_beq, is_bne, is_bgtz;
  logic is_alu, is_mem, is_br;
  logic r_ok, taken;
  logic [2:0] r_alu, ex_alu;

  assign is_r    = bus.Op == 6'b000000;
  assign is_addi = bus.Op == 6'b001000;
  assign is_lw   = bus.Op == 6'b100011;
  assign is_sw   = bus.Op == 6'b101011;
  assign is_beq  = bus.Op == 6'b000100;
  assign is_bne  = bus.Op == 6'b000101;
  assign is_bgtz = bus.Op == 6'b000111;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = 3'd0;
    case (bus.Fun)
      6'b100000: r_alu = 3'd2;
      6'b100001: r_alu = 3'd4;
      6'b100010: r_alu = 3'd6;
      6'b100011: r_alu = 3'd6;
      6'b100100: r_alu = 3'd0;
      6'b100101: r_alu = 3'd1;
      6'b000000: r_alu = 3'd5;
      6'b101010: r_alu = 3'd3;
      6'b101011: r_alu = 3'd7;
      default:   r_ok  = 1'b0;
    endcase
  end

  assign is_alu = (is_r & r_ok) | is_addi;
  assign is_mem = is_lw | is_sw;
  assign is_br  = is_beq | is_bne | is_bgtz;
  assign ex_alu = is_addi ? 3'd2 : r_alu;
  assign taken  = (is_beq & bus.equal)
                | (is_bne & ~bus.equal)
                | (is_bgtz & ~bus.equal & ~bus.sign);

  always_comb begin
    nxt    = FETCH;
    retire = 1'b0;
    case (st)
      FETCH:  nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          is_alu:  nxt = EXEC;
          is_mem:  nxt = ADDR;
          is_br:   nxt = BRANCH;
          default: nxt = TRAP;
        endcase
      end
      EXEC:   nxt = WB;
      WB:     retire = 1'b1;
      ADDR:   nxt = MEM;
      MEM: begin
        if (!bus.mem_ready) nxt = MEM;
        else if (is_lw)     nxt = LWB;
        else                retire = 1'b1;
      end
      LWB:    retire = 1'b1;
      BRANCH: retire = 1'b1;
      TRAP:   nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= FETCH;
      retired_q <= 32'd0;
    end else begin
      st <= nxt;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  logic pcwr, npc, irwr, iord, memrd, memwr;
  logic regwr, regdst, memtoreg, extop, alusrc;
  logic halt;
  logic [2:0] alu;

  // Gated by reset directly so strobes drop without waiting for a clock.
  always_comb begin
    pcwr     = 1'b0;
    npc      = 1'b0;
    irwr     = 1'b0;
    iord     = 1'b0;
    memrd    = 1'b0;
    memwr    = 1'b0;
    regwr    = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    extop    = 1'b0;
    alusrc   = 1'b0;
    halt     = 1'b0;
    alu      = 3'd0;
    if (!reset) begin
      case (st)
        FETCH: begin
          memrd = 1'b1;
          irwr  = bus.mem_ready;
          pcwr  = bus.mem_ready;
        end
        EXEC, WB: begin
          alu    = ex_alu;
          alusrc = is_addi;
          extop  = is_addi;
          regwr  = st == WB;
          regdst = (st == WB) & is_r;
        end
        ADDR, MEM: begin
          alu    = 3'd2;
          alusrc = 1'b1;
          extop  = 1'b1;
          iord   = st == MEM;
          memrd  = (st == MEM) & is_lw;
          memwr  = (st == MEM) & is_sw;
        end
        LWB: begin
          regwr    = 1'b1;
          memtoreg = 1'b1;
        end
        BRANCH: begin
          alu  = 3'd6;
          pcwr = taken;
          npc  = taken;
        end
        TRAP:    halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.PCWr     = pcwr;
  assign bus.nPC_sel  = npc;
  assign bus.IRWr     = irwr;
  assign bus.IorD     = iord;
  assign bus.MemRd    = memrd;
  assign bus.MemWr    = memwr;
  assign bus.RegWr    = regwr;
  assign bus.RegDst   = regdst;
  assign bus.MemToReg = memtoreg;
  assign bus.ExtOp    = extop;
  assign bus.ALUSrc   = alusrc;
  assign bus.ALUctr   = alu;
  assign bus.halt     = halt;
  assign bus.state    = st;
  assign bus.retired  = retired_q;
endmodule

// File: tb/tb_mc_control.sv
// Randomized scoreboard bench for mc_control: per-cycle
// expectations from an instruction-level model, checked at negedge.
module tb_mc_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_if bif ();
  mc_control dut (.clk(clk), .reset(reset), .bus(bif));

  localparam int PCWR = 10, NPC = 9, IRWR = 8, IORD = 7;
  localparam int MRD = 6, MWR = 5, RWR = 4, RDST = 3;
  localparam int M2R = 2, EXT = 1, SRC = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [10:0] ctl;
    logic [2:0]  alu;
    logic        halt;
    logic [31:0] ret;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int unsigned done_cnt = 0;

  logic [5:0] funs [9] = '{6'b100000, 6'b100001, 6'b100010,
                           6'b100011, 6'b100100, 6'b100101,
                           6'b000000, 6'b101010, 6'b101011};
  logic [2:0] fun_alu [9] = '{3'd2, 3'd4, 3'd6, 3'd6, 3'd0,
                              3'd1, 3'd5, 3'd3, 3'd7};

  function automatic obs_t sample();
    obs_t a;
    a.st  = bif.state;
    a.ctl = {bif.PCWr, bif.nPC_sel, bif.IRWr, bif.IorD,
             bif.MemRd, bif.MemWr, bif.RegWr, bif.RegDst,
             bif.MemToReg, bif.ExtOp, bif.ALUSrc};
    a.alu  = bif.ALUctr;
    a.halt = bif.halt;
    a.ret  = bif.retired;
    return a;
  endfunction

  function automatic obs_t base(input logic [3:0] s);
    obs_t e = '0;
    e.st  = s;
    e.ret = done_cnt;
    return e;
  endfunction

  always @(negedge clk) begin
    obs_t a, e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got st=%0d ctl=%b alu=%0d halt=%b ret=%0d, want st=%0d ctl=%b alu=%0d halt=%b ret=%0d",
                 t, $time, a.st, a.ctl, a.alu, a.halt, a.ret,
                 e.st, e.ctl, e.alu, e.halt, e.ret);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic cyc(input obs_t e, input string t, input logic rdy);
    bif.mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic do_fetch(input int fw);
    obs_t e;
    for (int w = 0; w <= fw; w++) begin
      bif.Op    = 6'($urandom);
      bif.Fun   = 6'($urandom);
      bif.equal = rbit();
      bif.sign  = rbit();
      e = base(4'd0);
      e.ctl[MRD] = 1'b1;
      if (w == fw) begin
        e.ctl[IRWR] = 1'b1;
        e.ctl[PCWR] = 1'b1;
      end
      cyc(e, "fetch", w == fw);
    end
  endtask

  task automatic do_decode(input logic [5:0] op, fun,
                           input logic eq, sg);
    bif.Op = op;
    bif.Fun = fun;
    bif.equal = eq;
    bif.sign = sg;
    cyc(base(4'd1), "decode", rbit());
  endtask

  task automatic run_instr(input logic [5:0] op, fun,
                           input logic eq, sg,
                           input int fw, mw, trap_cycles);
    obs_t e;
    logic [2:0] ra;
    bit rok;
    bit tk;
    rok = 0;
    ra = 3'd0;
    for (int i = 0; i < 9; i++)
      if (funs[i] == fun) begin
        rok = 1;
        ra = fun_alu[i];
      end
    do_fetch(fw);
    do_decode(op, fun, eq, sg);
    if ((op == 6'd0 && rok) || op == 6'b001000) begin
      e = base(4'd2);
      e.alu = (op == 6'd0) ? ra : 3'd2;
      e.ctl[SRC] = op != 6'd0;
      e.ctl[EXT] = op != 6'd0;
      cyc(e, "exec", rbit());
      e.st = 4'd3;
      e.ctl[RWR] = 1'b1;
      e.ctl[RDST] = op == 6'd0;
      cyc(e, "wb", rbit());
      done_cnt++;
    end else if (op == 6'b100011 || op == 6'b101011) begin
      e = base(4'd4);
      e.alu = 3'd2;
      e.ctl[SRC] = 1'b1;
      e.ctl[EXT] = 1'b1;
      cyc(e, "addr", rbit());
      e.st = 4'd5;
      e.ctl[IORD] = 1'b1;
      e.ctl[MRD] = op == 6'b100011;
      e.ctl[MWR] = op == 6'b101011;
      for (int w = 0; w <= mw; w++) cyc(e, "mem", w == mw);
      if (op == 6'b100011) begin
        e = base(4'd6);
        e.ctl[RWR] = 1'b1;
        e.ctl[M2R] = 1'b1;
        cyc(e, "lwb", rbit());
      end
      done_cnt++;
    end else if (op == 6'd4 || op == 6'd5 || op == 6'd7) begin
      tk = (op == 6'd4 && eq) || (op == 6'd5 && !eq)
        || (op == 6'd7 && !eq && !sg);
      e = base(4'd7);
      e.alu = 3'd6;
      e.ctl[PCWR] = tk;
      e.ctl[NPC] = tk;
      cyc(e, "branch", rbit());
      done_cnt++;
    end else begin
      for (int i = 0; i < trap_cycles; i++) begin
        e = base(4'd8);
        e.halt = 1'b1;
        cyc(e, "trap", rbit());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] op, fun;
    obs_t e;
    int k;
    bif.Op = 6'd0;
    bif.Fun = 6'd0;
    bif.equal = 1'b0;
    bif.sign = 1'b0;
    bif.mem_ready = 1'b1;
    #1;
    chk("reset_state", 32'(bif.state), 32'd0);
    chk("reset_memrd", 32'(bif.MemRd), 32'd0);
    chk("reset_pcwr", 32'(bif.PCWr), 32'd0);
    chk("reset_retired", bif.retired, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_instr(6'b000000, 6'b100000, 0, 0, 0, 0, 0);
    run_instr(6'b100011, 6'd0, 0, 0, 0, 2, 0);
    run_instr(6'b000100, 6'd0, 1, 0, 0, 0, 0);
    run_instr(6'b000101, 6'd0, 1, 0, 1, 0, 0);
    run_instr(6'b000111, 6'd0, 0, 1, 0, 0, 0);
    run_instr(6'b000111, 6'd0, 0, 0, 0, 0, 0);
    run_instr(6'b001000, 6'd9, 0, 0, 2, 0, 0);
    run_instr(6'b101011, 6'd0, 0, 0, 0, 1, 0);

    for (int n = 0; n < 20; n++) begin
      k = $urandom_range(4, 0);
      fun = 6'($urandom);
      case (k)
        0: begin
          op = 6'd0;
          fun = funs[$urandom_range(8, 0)];
        end
        1: op = 6'b001000;
        2: op = 6'b100011;
        3: op = 6'b101011;
        default: begin
          case ($urandom_range(2, 0))
            0: op = 6'd4;
            1: op = 6'd5;
            default: op = 6'd7;
          endcase
        end
      endcase
      run_instr(op, fun, rbit(), rbit(),
                $urandom_range(2, 0), $urandom_range(2, 0), 0);
    end
    chk("retired_after_28", bif.retired, 32'd28);

    run_instr(6'b111111, 6'd0, 0, 0, 0, 0, 10);
    reset = 1'b1;
    #1;
    chk("trap_reset_state", 32'(bif.state), 32'd0);
    chk("trap_reset_halt", 32'(bif.halt), 32'd0);
    chk("trap_reset_retired", bif.retired, 32'd0);
    done_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(6'b000000, 6'b111111, 0, 0, 0, 0, 3);
    reset = 1'b1;
    #1;
    done_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    do_fetch(0);
    do_decode(6'b101011, 6'd0, 0, 0);
    e = base(4'd4);
    e.alu = 3'd2;
    e.ctl[SRC] = 1'b1;
    e.ctl[EXT] = 1'b1;
    cyc(e, "sw_addr", 1'b0);
    bif.mem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("sw_mem_memwr", 32'(bif.MemWr), 32'd1);
    chk("sw_mem_iord", 32'(bif.IorD), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_memwr", 32'(bif.MemWr), 32'd0);
    chk("abort_state", 32'(bif.state), 32'd0);
    chk("abort_retired", bif.retired, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(6'b000000, 6'b100101, 0, 0, 0, 0, 0);
    do_fetch(0);
    chk("final_retired", bif.retired, 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
